// File: rtl/event_qualifier.sv
// Edge qualifier: detects qualified edges on sig_i while armed, timestamps them
// with a free-running cycle counter and queues them in a small ready/valid FIFO.
module event_qualifier #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic             oneshot_i,
    input  logic             arm_i,
    output logic             armed_o,
    output logic             fired_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CNT_W-1:0] evt_time_o,
    output logic             evt_rise_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Select which detected edge counts for a given mode; mode 3 never matches.
    function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic hit;
        case (mode)
            2'd0:    hit = rise;
            2'd1:    hit = fall;
            2'd2:    hit = rise | fall;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t             state_r, state_s;
    logic               sig_q_r;
    logic               primed_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   mem_time_r [DEPTH];
    logic               mem_rise_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [7:0]         drop_r;

    logic rise_s, fall_s, qual_s, full_s, pop_s, push_s, drop_s, nonempty_s;

    // Edge detection, qualification and FIFO handshake decisions.
    always_comb begin
        rise_s     = primed_r & sig_i & ~sig_q_r;
        fall_s     = primed_r & ~sig_i & sig_q_r;
        qual_s     = edge_hit(mode_i, rise_s, fall_s) & enable_i & (state_r == ST_WAIT);
        nonempty_s = (count_r != {CW{1'b0}});
        full_s     = (count_r == CW'(DEPTH));
        pop_s      = nonempty_s & evt_ready_i;
        push_s     = qual_s & (~full_s | pop_s);
        drop_s     = qual_s & full_s & ~pop_s;
    end

    // Next-state logic; a dropped one-shot event still completes the wait.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm_i) state_s = ST_WAIT;
                else       state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (qual_s && oneshot_i) state_s = ST_DONE;
                else                     state_s = ST_WAIT;
            end
            ST_DONE: begin
                if (arm_i) state_s = ST_DONE == ST_DONE ? ST_WAIT : ST_DONE;
                else       state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, input sampling, cycle counter and drop counter.
    always_ff @(posedge clk) begin
        sig_q_r <= sig_i;
        if (rst) begin
            state_r  <= ST_IDLE;
            primed_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            drop_r   <= 8'd0;
        end else begin
            state_r  <= state_s;
            primed_r <= 1'b1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (drop_s && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
            else                             drop_r <= drop_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // FIFO storage; contents are don't-care while the occupancy is zero.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_time_r[wr_ptr_r] <= cnt_r;
            mem_rise_r[wr_ptr_r] <= rise_s;
        end
    end

    assign armed_o     = (state_r == ST_WAIT);
    assign fired_o     = (state_r == ST_DONE);
    assign evt_valid_o = nonempty_s;
    assign evt_time_o  = nonempty_s ? mem_time_r[rd_ptr_r] : {CNT_W{1'b0}};
    assign evt_rise_o  = nonempty_s ? mem_rise_r[rd_ptr_r] : 1'b0;
    assign drop_cnt_o  = drop_r;

endmodule
